serial_adder: RTL and testbench

- Parametrised, digit-serial successor to the single-bit full-adder cell.
- Adds two WIDTH-bit operands plus carry-in, processing DIGIT bits per clock.
- Uses a valid/ready handshake on both the operand and result sides.
- Trades area for latency; intended for narrow-datapath FPGA arithmetic and as a teaching/verification vehicle for sequential arithmetic.

---
 rtl/serial_adder_pkg.sv | 23 ++
 rtl/adder_slice.sv | 35 +++
 rtl/serial_adder.sv | 132 +++++++++++++
 tb/tb_serial_adder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared state encoding and helpers for the digit-serial adder.
// Pure definitions: no timing and no flow control.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter width for WIDTH/DIGIT digit steps. A single step still needs a 1-bit counter.
    function automatic int cnt_width(input int width, input int digit);
        int n;
        n = (digit >= 1) ? width / digit : 1;
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    // One full-adder cell. The result is {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational DIGIT-bit ripple adder built from full-adder cells. Zero latency.
// No backpressure: the outputs follow the inputs in the same cycle.
module adder_slice
    import serial_adder_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             ci,
    output logic [DIGIT-1:0] s_d,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] c;
    logic [1:0]     fa;

    always_comb begin
        c    = '0;
        s_d  = '0;
        fa   = '0;
        c[0] = ci;
        for (int i = 0; i < DIGIT; i++) begin
            fa       = full_add(a_d[i], b_d[i], c[i]);
            s_d[i]   = fa[0];
            c[i+1]   = fa[1];
        end
    end

    assign co    = c[DIGIT];
    // c_msb is the carry into the top bit of the slice. It is used for signed overflow.
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH/DIGIT RUN cycles, with out_valid WIDTH/DIGIT+1 cycles after accept. SERIAL_ADDER_SUB_EN adds the sub port.
// Backpressure: in_ready stays low from accept until the result handshake completes, and the result is held while out_ready=0.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int DIG_SAFE = (DIGIT >= 1) ? DIGIT : 1;
    localparam int N_DIG    = WIDTH / DIG_SAFE;
    localparam int CNT_W    = cnt_width(WIDTH, DIGIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_DIG - 1);

    if (DIGIT < 1 || WIDTH < 1 || (WIDTH % DIG_SAFE) != 0) begin : g_bad_params
        $error("serial_adder: DIGIT (%0d) must be >= 1 and divide WIDTH (%0d)", DIGIT, WIDTH);
    end

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_nxt;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic [DIGIT-1:0] s_d;
    logic             co;
    logic             c_msb;

    logic [WIDTH-1:0] b_in;
    logic             cin_in;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + (cin^sub), so B is inverted once at accept time.
    assign b_in   = sub ? ~b : b;
    assign cin_in = cin ^ sub;
`else
    assign b_in   = b;
    assign cin_in = cin;
`endif

    adder_slice #(.DIGIT(DIGIT)) u_slice (
        .a_d   (a_sr[DIGIT-1:0]),
        .b_d   (b_sr[DIGIT-1:0]),
        .ci    (carry),
        .s_d   (s_d),
        .co    (co),
        .c_msb (c_msb)
    );

    // New digits enter at the MSB end. After N_DIG steps the LSB digit is at bit 0.
    assign sum_nxt = (sum_sr >> DIGIT) | (WIDTH'(s_d) << (WIDTH - DIGIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            cnt       <= '0;
            carry     <= 1'b0;
            a_sr      <= '0;
            b_sr      <= '0;
            sum_sr    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sr     <= a;
                        b_sr     <= b_in;
                        carry    <= cin_in;
                        cnt      <= '0;
                        sum_sr   <= '0;
                        in_ready <= 1'b0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sr   <= a_sr >> DIGIT;
                    b_sr   <= b_sr >> DIGIT;
                    sum_sr <= sum_nxt;
                    carry  <= co;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        sum       <= sum_nxt;
                        cout      <= co;
                        ovf       <= co ^ c_msb;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    a_hold_result: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(sum) && $stable(cout) && $stable(ovf)));

    a_one_side: assert property (@(posedge clk) disable iff (rst) !(in_ready && out_valid));

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboarded bench for serial_adder with DIGIT = 1, 4 and 8 at WIDTH = 8. Latency, hold and reset abort are checked.
// A single process advances time through step(), which also runs the output monitor.
`timescale 1ns/1ps
module tb_serial_adder;

    localparam int W  = 8;
    localparam int ND = 3;

    function automatic int dig_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 4 : 8;
    endfunction

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         iv   [ND];
    logic         rdy  [ND];
    logic         ov   [ND];
    logic         ordy [ND];
    logic         ci   [ND];
    logic         co   [ND];
    logic         of   [ND];
    logic [W-1:0] aa   [ND];
    logic [W-1:0] bb   [ND];
    logic [W-1:0] sm   [ND];
`ifdef SERIAL_ADDER_SUB_EN
    logic         sb   [ND];
`endif
    bit           dsub [ND];

    res_t q    [ND][$];
    int   acc  [ND];
    bit   pend [ND];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        serial_adder #(.WIDTH(W), .DIGIT(dig_of(g))) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv[g]),
            .in_ready  (rdy[g]),
            .a         (aa[g]),
            .b         (bb[g]),
            .cin       (ci[g]),
`ifdef SERIAL_ADDER_SUB_EN
            .sub       (sb[g]),
`endif
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .sum       (sm[g]),
            .cout      (co[g]),
            .ovf       (of[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic s);
        logic [W:0]   t;
        logic [W-1:0] yy;
        res_t         r;
        yy     = s ? ~y : y;
        t      = {1'b0, x} + {1'b0, yy} + (W+1)'(c ^ s);
        r.sum  = t[W-1:0];
        r.cout = t[W];
        r.ovf  = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
        return r;
    endfunction

    task automatic monitor();
        res_t e;
        for (int g = 0; g < ND; g++) begin
            if (rst) begin
                q[g].delete();
                pend[g] = 1'b0;
            end else begin
                if (iv[g] && rdy[g]) begin
                    q[g].push_back(model(aa[g], bb[g], ci[g], dsub[g]));
                    acc[g]  = cyc;
                    pend[g] = 1'b1;
                end
                if (ov[g] && pend[g]) begin
                    check($sformatf("d%0d_latency", g), 32'(cyc - acc[g]), 32'(W / dig_of(g) + 1));
                    pend[g] = 1'b0;
                end
                if (ov[g] && ordy[g]) begin
                    if (q[g].size() == 0) begin
                        check($sformatf("d%0d_spurious_out", g), 32'(q[g].size()), 32'd1);
                    end else begin
                        e = q[g].pop_front();
                        check($sformatf("d%0d_sum", g),  32'(sm[g]), 32'(e.sum));
                        check($sformatf("d%0d_cout", g), 32'(co[g]), 32'(e.cout));
                        check($sformatf("d%0d_ovf", g),  32'(of[g]), 32'(e.ovf));
                    end
                end
            end
        end
    endtask

    // Monitor at the falling edge, then return 1 ns after the rising edge for driving.
    task automatic step();
        @(negedge clk);
        cyc++;
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input logic s);
        int t = 0;
        aa[d] = x; bb[d] = y; ci[d] = c; dsub[d] = s;
`ifdef SERIAL_ADDER_SUB_EN
        sb[d] = s;
`endif
        iv[d] = 1'b1;
        while (!rdy[d] && t < 50) begin
            step();
            t++;
        end
        if (!rdy[d]) check($sformatf("d%0d_accept_timeout", d), 32'(rdy[d]), 32'd1);
        step();
        iv[d] = 1'b0;
    endtask

    task automatic wait_done(input int d);
        int t = 0;
        while (q[d].size() != 0 && t < 100) begin
            step();
            t++;
        end
        if (q[d].size() != 0) check($sformatf("d%0d_result_timeout", d), 32'(q[d].size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int seen;
        rst = 1'b1;
        for (int d = 0; d < ND; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b1; aa[d] = '0; bb[d] = '0; ci[d] = 1'b0; dsub[d] = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sb[d] = 1'b0;
`endif
        end
        repeat (3) step();
        rst = 1'b0;

        check("rst_in_ready",  32'(rdy[0]), 32'd1);
        check("rst_out_valid", 32'(ov[0]),  32'd0);
        check("rst_sum",       32'(sm[0]),  32'd0);
        check("rst_cout",      32'(co[0]),  32'd0);
        check("rst_ovf",       32'(of[0]),  32'd0);

        send(0, 8'h5A, 8'h3C, 1'b0, 1'b0); wait_done(0);
        send(0, 8'hFF, 8'h01, 1'b0, 1'b0); wait_done(0);
        send(0, 8'h7F, 8'h00, 1'b1, 1'b0); wait_done(0);
        send(1, 8'hFF, 8'h00, 1'b1, 1'b0); wait_done(1);
        send(2, 8'h80, 8'h80, 1'b0, 1'b0); wait_done(2);

        for (int i = 0; i < 8; i++) begin
            for (int d = 0; d < ND; d++) begin
                send(d, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
                wait_done(d);
            end
        end

        // The result is stalled in DONE while new operands are offered.
        ordy[0] = 1'b0;
        send(0, 8'h12, 8'h34, 1'b0, 1'b0);
        t = 0;
        while (!ov[0] && t < 50) begin
            step();
            t++;
        end
        check("bp_out_valid_rise", 32'(ov[0]), 32'd1);
        aa[0] = 8'hF0; bb[0] = 8'h20; ci[0] = 1'b1; iv[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", 32'(rdy[0]), 32'd0);
            check("bp_out_valid", 32'(ov[0]), 32'd1);
            check("bp_sum",  32'(sm[0]), 32'h46);
            check("bp_cout", 32'(co[0]), 32'd0);
            check("bp_ovf",  32'(of[0]), 32'd0);
            step();
        end
        ordy[0] = 1'b1;
        step();
        check("bp_release_in_ready",  32'(rdy[0]), 32'd1);
        check("bp_release_out_valid", 32'(ov[0]),  32'd0);
        check("bp_idle_sum_kept",     32'(sm[0]),  32'h46);
        step();
        iv[0] = 1'b0;
        check("bp_new_accept", 32'(q[0].size()), 32'd1);
        wait_done(0);

`ifdef SERIAL_ADDER_SUB_EN
        send(0, 8'h05, 8'h07, 1'b0, 1'b1); wait_done(0);
        send(0, 8'h80, 8'h01, 1'b0, 1'b1); wait_done(0);
        send(1, 8'h05, 8'h07, 1'b1, 1'b1); wait_done(1);
        send(2, 8'h80, 8'h01, 1'b0, 1'b1); wait_done(2);
`endif

        // A reset in the fourth RUN cycle drops the operation.
        send(0, 8'h11, 8'h22, 1'b0, 1'b0);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_run_in_ready",  32'(rdy[0]), 32'd1);
        check("rst_run_out_valid", 32'(ov[0]),  32'd0);
        check("rst_run_sum",       32'(sm[0]),  32'd0);
        check("rst_run_cout",      32'(co[0]),  32'd0);
        check("rst_run_ovf",       32'(of[0]),  32'd0);
        seen = 0;
        repeat (12) begin
            step();
            if (ov[0]) seen++;
        end
        check("rst_run_no_result", 32'(seen), 32'd0);

        send(0, 8'h01, 8'h01, 1'b1, 1'b0); wait_done(0);

        check("sb_empty", 32'(q[0].size() + q[1].size() + q[2].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
